// File: rtl/unpacked_elastic_fifo_if.sv
// Handshake bundle for unpacked_elastic_fifo: producer stream, consumer stream and occupancy status.
// The FIFO connects through the slave modport; the surrounding logic uses master.
interface unpacked_elastic_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IN_NUM     = 16,
    parameter int DEPTH      = 4
);
    logic [DATA_WIDTH-1:0]      data_in [IN_NUM];
    logic                       data_in_valid;
    logic                       data_in_ready;
    logic [DATA_WIDTH-1:0]      data_out [IN_NUM];
    logic                       data_out_valid;
    logic                       data_out_ready;
    logic [$clog2(DEPTH+1)-1:0] count;
    logic                       almost_full;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, count, almost_full
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, count, almost_full
    );
endinterface

// File: rtl/unpacked_elastic_fifo.sv
// DEPTH-entry circular FIFO of unpacked IN_NUM x DATA_WIDTH vectors with valid/ready on both sides,
// occupancy count, almost-full flag and synchronous flush. Outputs come from registers only.
module unpacked_elastic_fifo #(
    parameter int DATA_WIDTH        = 8,
    parameter int IN_NUM            = 16,
    parameter int DEPTH             = 4,
    parameter int ALMOST_FULL_LEVEL = 3
) (
    input logic                    clk,
    input logic                    rst,
    input logic                    flush,
    unpacked_elastic_fifo_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH][IN_NUM];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [PTR_W-1:0]      wr_ptr_nxt_s;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  in_ready_s;
    logic                  out_valid_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  wr_en_s;

    // Non-power-of-two depths need an explicit wrap rather than natural overflow.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Readiness depends only on rst and the count register, never on data_out_ready.
    assign in_ready_s  = rst & (count_r < CNT_W'(DEPTH));
    assign out_valid_s = (count_r != {CNT_W{1'b0}});
    assign push_s      = bus.data_in_valid & in_ready_s;
    assign pop_s       = out_valid_s & bus.data_out_ready;
    assign wr_en_s     = push_s & ~flush;

    // Next pointer and occupancy; flush overrides any push or pop in the same cycle.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = next_ptr(wr_ptr_r);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = next_ptr(rd_ptr_r);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Vector storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < IN_NUM; i++) begin
                mem_r[wr_ptr_r][i] <= bus.data_in[i];
            end
        end
    end

    for (genvar g = 0; g < IN_NUM; g++) begin : g_lane
        assign bus.data_out[g] = mem_r[rd_ptr_r][g];
    end

    assign bus.data_in_ready  = in_ready_s;
    assign bus.data_out_valid = out_valid_s;
    assign bus.count          = count_r;
    assign bus.almost_full    = (count_r >= CNT_W'(ALMOST_FULL_LEVEL));
endmodule

// File: tb/tb_unpacked_elastic_fifo.sv
// Directed bench for unpacked_elastic_fifo: three instances (DEPTH 4, 3 and 5) with 4 lanes of 8 bits.
module tb_unpacked_elastic_fifo;
    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    unpacked_elastic_fifo_if #(.DATA_WIDTH(8), .IN_NUM(4), .DEPTH(4)) b4 ();
    unpacked_elastic_fifo_if #(.DATA_WIDTH(8), .IN_NUM(4), .DEPTH(3)) b3 ();
    unpacked_elastic_fifo_if #(.DATA_WIDTH(8), .IN_NUM(4), .DEPTH(5)) b5 ();

    unpacked_elastic_fifo #(.DATA_WIDTH(8), .IN_NUM(4), .DEPTH(4), .ALMOST_FULL_LEVEL(3)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b4));
    unpacked_elastic_fifo #(.DATA_WIDTH(8), .IN_NUM(4), .DEPTH(3), .ALMOST_FULL_LEVEL(2)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b3));
    unpacked_elastic_fifo #(.DATA_WIDTH(8), .IN_NUM(4), .DEPTH(5), .ALMOST_FULL_LEVEL(4)) u_d5 (
        .clk(clk), .rst(rst), .flush(flush), .bus(b5));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fillvec(input int k);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(16 * k + i);
        return r;
    endfunction

    function automatic logic [31:0] streamvec(input int k);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(64 * i + k);
        return r;
    endfunction

    task automatic drive4(input logic [31:0] w, input logic v);
        for (int i = 0; i < 4; i++) b4.data_in[i] = w[8*i +: 8];
        b4.data_in_valid = v;
    endtask

    task automatic drive3(input logic [31:0] w, input logic v);
        for (int i = 0; i < 4; i++) b3.data_in[i] = w[8*i +: 8];
        b3.data_in_valid = v;
    endtask

    task automatic drive5(input logic [31:0] w, input logic v);
        for (int i = 0; i < 4; i++) b5.data_in[i] = w[8*i +: 8];
        b5.data_in_valid = v;
    endtask

    function automatic logic [31:0] head4();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b4.data_out[i];
        return r;
    endfunction

    function automatic logic [31:0] head3();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b3.data_out[i];
        return r;
    endfunction

    function automatic logic [31:0] head5();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b5.data_out[i];
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_checks++; if (b4.count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", b4.count); end
        n_checks++; if (b4.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", b4.data_out_valid); end
        n_checks++; if (b4.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", b4.data_in_ready); end
        n_checks++; if (b4.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", b4.almost_full); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (b4.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", b4.data_in_ready); end
        step();
    endtask

    task automatic test_fill();
        b4.data_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive4(fillvec(k), 1'b1);
            n_checks++; if (b4.data_in_ready !== (k < 4)) begin n_fail++; $display("FAIL fill_ready k=%0d: got %b want %b", k, b4.data_in_ready, (k < 4)); end
            n_checks++; if (b4.count !== 3'(k)) begin n_fail++; $display("FAIL fill_count k=%0d: got %0d want %0d", k, b4.count, k); end
            n_checks++; if (b4.almost_full !== (k >= 3)) begin n_fail++; $display("FAIL fill_af k=%0d: got %b want %b", k, b4.almost_full, (k >= 3)); end
            step();
        end
        for (int s = 0; s < 2; s++) begin
            n_checks++; if (b4.count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", b4.count); end
            n_checks++; if (b4.data_out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b want 1", b4.data_out_valid); end
            n_checks++; if (head4() !== fillvec(0)) begin n_fail++; $display("FAIL stall_hold: got %h want %h", head4(), fillvec(0)); end
            step();
        end
    endtask

    task automatic test_drain();
        int exp_cnt [6];
        exp_cnt = '{4, 3, 3, 2, 1, 0};
        b4.data_out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            n_checks++; if (b4.count !== 3'(exp_cnt[j])) begin n_fail++; $display("FAIL drain_count j=%0d: got %0d want %0d", j, b4.count, exp_cnt[j]); end
            n_checks++; if (b4.data_out_valid !== (j < 5)) begin n_fail++; $display("FAIL drain_valid j=%0d: got %b want %b", j, b4.data_out_valid, (j < 5)); end
            if (j < 5) begin
                n_checks++; if (head4() !== fillvec(j)) begin n_fail++; $display("FAIL drain_data j=%0d: got %h want %h", j, head4(), fillvec(j)); end
            end
            if (j == 0) begin
                n_checks++; if (b4.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_no_passthru: got %b want 0", b4.data_in_ready); end
            end
            if (j == 1) begin
                n_checks++; if (b4.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_pop: got %b want 1", b4.data_in_ready); end
            end
            step();
            if (j == 1) drive4(32'h0, 1'b0);
        end
        b4.data_out_ready = 1'b0;
    endtask

    task automatic test_stream();
        b3.data_out_ready = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            if (c < 20) drive3(streamvec(c), 1'b1);
            else        drive3(32'h0, 1'b0);
            if (c == 0) begin
                n_checks++; if (b3.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %b want 0", b3.data_out_valid); end
            end else begin
                n_checks++; if (b3.data_out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid c=%0d: got %b want 1", c, b3.data_out_valid); end
                n_checks++; if (b3.count !== 2'd1) begin n_fail++; $display("FAIL stream_count c=%0d: got %0d want 1", c, b3.count); end
                n_checks++; if (b3.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d: got %b want 1", c, b3.data_in_ready); end
                n_checks++; if (head3() !== streamvec(c - 1)) begin n_fail++; $display("FAIL stream_data c=%0d: got %h want %h", c, head3(), streamvec(c - 1)); end
            end
            step();
        end
        n_checks++; if (b3.count !== 2'd0) begin n_fail++; $display("FAIL stream_end_count: got %0d want 0", b3.count); end
        b3.data_out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] w;
        logic        v;
        logic        r;
        logic        do_push;
        logic        do_pop;
        int          model;
        int          pushed;
        int          popped;
        int          cyc;
        model = 0; pushed = 0; popped = 0; cyc = 0;
        while (popped < 1000 && cyc < 20000) begin
            n_checks++; if (b5.count !== 3'(model)) begin n_fail++; $display("FAIL rand_count cyc=%0d: got %0d want %0d", cyc, b5.count, model); end
            n_checks++; if (b5.count > 3'd5) begin n_fail++; $display("FAIL rand_overflow cyc=%0d: got %0d want <=5", cyc, b5.count); end
            n_checks++; if (b5.data_out_valid !== (model > 0)) begin n_fail++; $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, b5.data_out_valid, (model > 0)); end
            n_checks++; if (b5.data_in_ready !== (model < 5)) begin n_fail++; $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, b5.data_in_ready, (model < 5)); end
            n_checks++; if (b5.almost_full !== (model >= 4)) begin n_fail++; $display("FAIL rand_af cyc=%0d: got %b want %b", cyc, b5.almost_full, (model >= 4)); end
            if (model > 0) begin
                n_checks++; if (head5() !== q[0]) begin n_fail++; $display("FAIL rand_data cyc=%0d: got %h want %h", cyc, head5(), q[0]); end
            end
            v = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 1'($urandom_range(0, 1));
            w = $urandom;
            drive5(w, v);
            b5.data_out_ready = r;
            do_push = v && (model < 5);
            do_pop  = r && (model > 0);
            step();
            if (do_pop) begin
                void'(q.pop_front());
                popped++;
                model--;
            end
            if (do_push) begin
                q.push_back(w);
                pushed++;
                model++;
            end
            cyc++;
        end
        n_checks++; if (popped != 1000) begin n_fail++; $display("FAIL rand_timeout: got %0d pops want 1000", popped); end
        drive5(32'h0, 1'b0);
        b5.data_out_ready = 1'b0;
    endtask

    task automatic test_flush();
        b4.data_out_ready = 1'b0;
        drive4(32'h11223344, 1'b1); step();
        drive4(32'h55667788, 1'b1); step();
        drive4(32'hDEADBEEF, 1'b1);
        flush = 1'b1;
        n_checks++; if (b4.count !== 3'd2) begin n_fail++; $display("FAIL preflush_count: got %0d want 2", b4.count); end
        step();
        flush = 1'b0;
        drive4(32'hCAFEF00D, 1'b1);
        n_checks++; if (b4.count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", b4.count); end
        n_checks++; if (b4.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", b4.data_out_valid); end
        n_checks++; if (b4.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", b4.data_in_ready); end
        step();
        drive4(32'h0, 1'b0);
        n_checks++; if (b4.count !== 3'd1) begin n_fail++; $display("FAIL postflush_count: got %0d want 1", b4.count); end
        n_checks++; if (head4() !== 32'hCAFEF00D) begin n_fail++; $display("FAIL postflush_data: got %h want cafef00d", head4()); end
        b4.data_out_ready = 1'b1;
        step();
        b4.data_out_ready = 1'b0;
        n_checks++; if (b4.count !== 3'd0) begin n_fail++; $display("FAIL postflush_drain: got %0d want 0", b4.count); end
    endtask

    task automatic test_async_reset();
        b4.data_out_ready = 1'b0;
        drive4(32'hA1A2A3A4, 1'b1); step();
        drive4(32'hB1B2B3B4, 1'b1); step();
        drive4(32'hC1C2C3C4, 1'b1); step();
        drive4(32'h0, 1'b0);
        n_checks++; if (b4.count !== 3'd3) begin n_fail++; $display("FAIL prereset_count: got %0d want 3", b4.count); end
        n_checks++; if (b4.almost_full !== 1'b1) begin n_fail++; $display("FAIL prereset_af: got %b want 1", b4.almost_full); end
        #3;
        rst = 1'b0;
        #1;
        n_checks++; if (b4.count !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", b4.count); end
        n_checks++; if (b4.data_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", b4.data_out_valid); end
        n_checks++; if (b4.data_in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready: got %b want 0", b4.data_in_ready); end
        n_checks++; if (b4.almost_full !== 1'b0) begin n_fail++; $display("FAIL areset_af: got %b want 0", b4.almost_full); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (b4.data_in_ready !== 1'b1) begin n_fail++; $display("FAIL arelease_ready: got %b want 1", b4.data_in_ready); end
        step();
        drive4(32'h0F1E2D3C, 1'b1);
        step();
        drive4(32'h0, 1'b0);
        n_checks++; if (b4.count !== 3'd1) begin n_fail++; $display("FAIL postreset_count: got %0d want 1", b4.count); end
        n_checks++; if (b4.data_out_valid !== 1'b1) begin n_fail++; $display("FAIL postreset_valid: got %b want 1", b4.data_out_valid); end
        n_checks++; if (head4() !== 32'h0F1E2D3C) begin n_fail++; $display("FAIL postreset_data: got %h want 0f1e2d3c", head4()); end
    endtask

    initial begin
        drive4(32'h0, 1'b0);
        drive3(32'h0, 1'b0);
        drive5(32'h0, 1'b0);
        b4.data_out_ready = 1'b0;
        b3.data_out_ready = 1'b0;
        b5.data_out_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_random();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/unpacked_elastic_fifo.md
Name: unpacked_elastic_fifo

Overview:
- Parametrised successor to the single-entry unpacked skid stage: a DEPTH-entry circular FIFO for unpacked vectors of IN_NUM lanes × DATA_WIDTH bits.
- Valid/ready on both sides, with an occupancy count, an almost-full flag and a synchronous flush.
- Sits between dataflow compute stages where bursty producers and consumers need more slack than one skid register gives.
- No combinational path from data_out_ready to data_in_ready, or from data_in to data_out.

Parameters:
- DATA_WIDTH, 8, bits per lane.
- IN_NUM, 16, lanes per vector.
- DEPTH, 4, entries; legal range ≥2; need not be a power of two.
- ALMOST_FULL_LEVEL, 3, count at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted at 0).
- flush  input  1  synchronous clear of all stored entries.
- data_in  input  DATA_WIDTH × [IN_NUM]  unpacked input vector.
- data_in_valid  input  1  producer has a vector.
- data_in_ready  output  1  FIFO can accept.
- data_out  output  DATA_WIDTH × [IN_NUM]  unpacked head-of-queue vector.
- data_out_valid  output  1  head entry present.
- data_out_ready  input  1  consumer accepts.
- count  output  $clog2(DEPTH+1)  current occupancy.
- almost_full  output  1  count ≥ ALMOST_FULL_LEVEL.

Behaviour:
- State: storage mem[DEPTH] of unpacked vectors, wr_ptr, rd_ptr (0..DEPTH-1) and count (0..DEPTH).
- Reset (rst=0, asynchronous):
  - count, wr_ptr and rd_ptr go to 0; data_out_valid=0, almost_full=0.
  - data_in_ready is forced to 0 while rst=0. It rises combinationally on reset release because count=0.
  - mem is not reset. data_out is don't-care while data_out_valid=0.
- Push = data_in_valid & data_in_ready. Pop = data_out_valid & data_out_ready.
- data_in_ready = rst & (count < DEPTH).
- data_out_valid = (count > 0).
- data_out = mem[rd_ptr]. It is driven from registers only.
- almost_full is decoded from the count register.
- On push: mem[wr_ptr] <= data_in, then wr_ptr advances. Wrap rule: at DEPTH-1 the pointer goes to 0, otherwise it increments by 1.
- On pop: rd_ptr advances with the same wrap rule.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Latency: a vector pushed into an empty FIFO at edge t appears on data_out with data_out_valid=1 immediately after edge t (one cycle). There is no bypass.
- Throughput: 1 vector/cycle sustained when both sides are always ready and DEPTH≥2.
- When full: data_in_ready=0 even if data_out_ready=1 in the same cycle. No same-cycle full-state pass-through. The producer sees ready again the cycle after a pop.
- When empty: data_out_valid=0. data_out_ready is ignored and the pointers hold.
- Flush (sampled at clk edge, rst=1):
  - count, wr_ptr and rd_ptr go to 0, overriding any push or pop in that cycle.
  - A vector presented with data_in_valid in the flush cycle is dropped, even though data_in_ready may be high.
  - Outputs reflect empty on the next cycle.
- Lane ordering: data_out[i] always corresponds to data_in[i] of the same pushed vector. The FIFO stores in order: first in, first out.
- Stability: while data_out_valid=1 and data_out_ready=0, data_out and data_out_valid hold unchanged.
- Reset asserted mid-stream: all stored entries are lost and outputs go to reset values immediately. This is asynchronous, with no clock required.

Test Plan:
- Fill with consumer stalled (DEPTH=4, IN_NUM=4, DATA_WIDTH=8; push vectors with lane i = 16·k+i for k=0..4, data_out_ready=0):
  - Pushes k=0..3 are accepted; count reaches 4 and data_in_ready=0.
  - almost_full=1 from count=3.
  - Vector k=4 is held until data_out_ready rises.
- Drain order: after the fill, assert data_out_ready=1.
  - data_out lanes are 0x00–0x03, 0x10–0x13, 0x20–0x23, 0x30–0x33 on consecutive cycles.
  - Vector k=4 is accepted after the first pop.
- Streaming with both sides always ready for 20 vectors (DEPTH=3, non-power-of-two):
  - One output per cycle after a 1-cycle initial latency.
  - count stays at 1 and pointers wrap correctly.
  - Output sequence equals input sequence.
- Random valid/ready (50% each), 1000 vectors, DEPTH=5:
  - Scoreboard matches in order with no loss or duplication.
  - count always equals pushes minus pops, and is never >5.
- Flush with count=2 while data_in_valid=1:
  - Next cycle count=0, data_out_valid=0.
  - The flush-cycle vector is dropped.
  - The next pushed vector appears first on data_out.
- Asynchronous reset mid-burst (rst=0 between clock edges with count=3):
  - data_out_valid=0, data_in_ready=0 and count=0 immediately.
  - After release, data_in_ready=1 and the first post-reset push is output correctly.
